// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 16-bit CPU. Single-cycle ALU plus an iterative
// shift-add multiplier; results are held for writeback until the next completion.
`timescale 1ns/1ps
module exec_unit #(
    parameter int DW  = 16,
    parameter int PCW = 8
) (
    input  logic           CLK_EX,
    input  logic           RESET_N,
    input  logic           START,
    input  logic [4:0]     OP_CODE,
    input  logic [7:0]     OP_DATA,
    input  logic [2:0]     N_DST,
    input  logic [DW-1:0]  SRC_A,
    input  logic [DW-1:0]  SRC_B,
    input  logic [PCW-1:0] PC_IN,
    output logic           BUSY,
    output logic           DONE,
    output logic [DW-1:0]  REG_IN,
    output logic [2:0]     N_REG,
    output logic           REG_WEN,
    output logic [PCW-1:0] PC_OUT,
    output logic           FLAG_Z,
    output logic           FLAG_C
);

    localparam int CW = $clog2(DW);

    typedef enum logic [4:0] {
        OP_ADD = 5'h00,
        OP_SUB = 5'h01,
        OP_AND = 5'h02,
        OP_OR  = 5'h03,
        OP_XOR = 5'h04,
        OP_SL  = 5'h05,
        OP_SR  = 5'h06,
        OP_MUL = 5'h07,
        OP_LDL = 5'h08,
        OP_LDH = 5'h09,
        OP_MOV = 5'h0A,
        OP_CMP = 5'h0B,
        OP_JMP = 5'h0C,
        OP_JZ  = 5'h0D
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN
    } state_e;

    state_e state;

    // Single-cycle datapath, evaluated on the raw issue inputs
    logic [DW:0]    wide_sum;
    logic [DW:0]    wide_diff;
    logic [PCW-1:0] pc_inc;
    logic [DW-1:0]  alu_res;
    logic           alu_wen;
    logic           alu_flags;
    logic           alu_c;
    logic           alu_z;
    logic [PCW-1:0] alu_pc;
    logic           is_mul;

    assign wide_sum  = {1'b0, SRC_A} + {1'b0, SRC_B};
    assign wide_diff = {1'b0, SRC_A} - {1'b0, SRC_B};
    assign pc_inc    = PC_IN + PCW'(1);
    assign is_mul    = (OP_CODE == OP_MUL);
    assign alu_z     = (alu_res == '0);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        alu_res   = '0;
        alu_wen   = 1'b0;
        alu_flags = 1'b0;
        alu_c     = 1'b0;
        alu_pc    = pc_inc;
        case (OP_CODE)
            OP_ADD: begin
                alu_res   = wide_sum[DW-1:0];
                alu_c     = wide_sum[DW];
                alu_flags = 1'b1;
                alu_wen   = 1'b1;
            end
            OP_SUB: begin
                alu_res   = wide_diff[DW-1:0];
                alu_c     = wide_diff[DW];
                alu_flags = 1'b1;
                alu_wen   = 1'b1;
            end
            OP_AND: begin
                alu_res = SRC_A & SRC_B;
                alu_wen = 1'b1;
            end
            OP_OR: begin
                alu_res = SRC_A | SRC_B;
                alu_wen = 1'b1;
            end
            OP_XOR: begin
                alu_res = SRC_A ^ SRC_B;
                alu_wen = 1'b1;
            end
            OP_SL: begin
                alu_res = {SRC_A[DW-2:0], 1'b0};
                alu_wen = 1'b1;
            end
            OP_SR: begin
                alu_res = {1'b0, SRC_A[DW-1:1]};
                alu_wen = 1'b1;
            end
            OP_MUL: begin
                alu_wen = 1'b1;
            end
            OP_LDL: begin
                alu_res = {SRC_A[DW-1:8], OP_DATA};
                alu_wen = 1'b1;
            end
            OP_LDH: begin
                alu_res = {OP_DATA, SRC_A[DW-9:0]};
                alu_wen = 1'b1;
            end
            OP_MOV: begin
                alu_res = SRC_B;
                alu_wen = 1'b1;
            end
            // Compare: difference drives the flags only, nothing is written back
            OP_CMP: begin
                alu_res   = wide_diff[DW-1:0];
                alu_c     = wide_diff[DW];
                alu_flags = 1'b1;
            end
            OP_JMP: begin
                alu_pc = PCW'(OP_DATA);
            end
            OP_JZ: begin
                if (FLAG_Z) begin
                    alu_pc = PCW'(OP_DATA);
                end
            end
            default: begin
            end
        endcase
    end

    // Shift-add multiplier state
    logic [DW-1:0]  mul_a;
    logic [DW-1:0]  mul_b;
    logic [DW-1:0]  mul_acc;
    logic [DW-1:0]  mul_sum;
    logic [CW-1:0]  mul_cnt;
    logic [2:0]     mul_dst;
    logic [PCW-1:0] mul_pc;

    assign mul_sum = mul_acc + (mul_b[0] ? mul_a : '0);

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge CLK_EX or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            REG_IN  <= '0;
            N_REG   <= '0;
            REG_WEN <= 1'b0;
            PC_OUT  <= '0;
            FLAG_Z  <= 1'b0;
            FLAG_C  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_dst <= '0;
            mul_pc  <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE, S_FIN: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    if (START) begin
                        if (is_mul) begin
                            mul_a   <= SRC_A;
                            mul_b   <= SRC_B;
                            mul_acc <= '0;
                            mul_cnt <= '0;
                            mul_dst <= N_DST;
                            mul_pc  <= pc_inc;
                            BUSY    <= 1'b1;
                            state   <= S_MUL;
                        end else begin
                            if (alu_wen) begin
                                REG_IN <= alu_res;
                                N_REG  <= N_DST;
                            end
                            REG_WEN <= alu_wen;
                            PC_OUT  <= alu_pc;
                            if (alu_flags) begin
                                FLAG_Z <= alu_z;
                                FLAG_C <= alu_c;
                            end
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_MUL: begin
                    mul_acc <= mul_sum;
                    mul_a   <= {mul_a[DW-2:0], 1'b0};
                    mul_b   <= {1'b0, mul_b[DW-1:1]};
                    mul_cnt <= mul_cnt + CW'(1);
                    // Last iteration: publish the product in the same edge
                    if (mul_cnt == CW'(DW - 1)) begin
                        REG_IN  <= mul_sum;
                        N_REG   <= mul_dst;
                        REG_WEN <= 1'b1;
                        PC_OUT  <= mul_pc;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= S_FIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
